// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data memory arbiter between core load/store path and debug port
//
// Purpose:
//    Shares one synchronous-read DataMemory between the core datapath and a
//    debug/loader port. The core has fixed priority. A starvation counter
//    forces a debug grant after MAX_WAIT lost cycles. Reads take one extra
//    cycle, and the requester's return cycle is tracked by the FSM.
//    The core is stalled until its access completes.
//
// Configuration macro:
//    MEM_ARB_PERF_EN - adds perf_stall_cnt_o / perf_dbg_cnt_o counters.
//
// Ports:
//    clk, rst                 clock, synchronous active-high reset
//    core_req_i/we_i/addr_i/wdata_i   core access request
//    core_rdata_o, core_stall_o       core load data / stall
//    dbg_req_i/we_i/addr_i/wdata_i    debug access request (held until grant)
//    dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o   debug grant / read return
//    mem_addr_o/wdata_o/write_o/read_o, mem_rdata_i   DataMemory interface
//    perf_stall_cnt_o, perf_dbg_cnt_o (MEM_ARB_PERF_EN only)

module dmem_arbiter #(
   parameter int MEM_WIDTH  = 8,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  core_req_i,
   input  logic                  core_we_i,
   input  logic [MEM_WIDTH-1:0]  core_addr_i,
   input  logic [DATA_WIDTH-1:0] core_wdata_i,
   output logic [DATA_WIDTH-1:0] core_rdata_o,
   output logic                  core_stall_o,
   input  logic                  dbg_req_i,
   input  logic                  dbg_we_i,
   input  logic [MEM_WIDTH-1:0]  dbg_addr_i,
   input  logic [DATA_WIDTH-1:0] dbg_wdata_i,
   output logic                  dbg_gnt_o,
   output logic                  dbg_rvalid_o,
   output logic [DATA_WIDTH-1:0] dbg_rdata_o,
   output logic [MEM_WIDTH-1:0]  mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   output logic                  mem_write_o,
   output logic                  mem_read_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]           perf_stall_cnt_o,
   output logic [31:0]           perf_dbg_cnt_o
`endif
);

   // MAX_WAIT=0 would give a zero-width counter; keep one bit, it simply stays 0.
   localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CORE_RD = 2'd1,
      S_DBG_RD  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] starve_q, starve_d;
   logic             is_idle;
   logic             dbg_win;
   logic             core_win;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      starve_d     = starve_q;
      is_idle      = 1'b0;
      dbg_win      = 1'b0;
      core_win     = 1'b0;
      core_rdata_o = '0;
      core_stall_o = 1'b0;
      dbg_gnt_o    = 1'b0;
      dbg_rvalid_o = 1'b0;
      dbg_rdata_o  = '0;
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
      mem_write_o  = 1'b0;
      mem_read_o   = 1'b0;

      if (rst) begin
         // All outputs held at 0; any in-flight read return is dropped.
         state_d  = S_IDLE;
         starve_d = '0;
      end else begin
         is_idle  = (state_q == S_IDLE);
         dbg_win  = is_idle && dbg_req_i && (!core_req_i || (starve_q == MAX_CNT));
         core_win = is_idle && core_req_i && !dbg_win;

         if (dbg_win) begin
            dbg_gnt_o   = 1'b1;
            mem_addr_o  = dbg_addr_i;
            mem_wdata_o = dbg_wdata_i;
            mem_write_o = dbg_we_i;
            mem_read_o  = !dbg_we_i;
            if (!dbg_we_i) begin
               state_d = S_DBG_RD;
            end
         end else if (core_win) begin
            mem_addr_o  = core_addr_i;
            mem_wdata_o = core_wdata_i;
            mem_write_o = core_we_i;
            mem_read_o  = !core_we_i;
            if (!core_we_i) begin
               state_d = S_CORE_RD;
            end
         end

         case (state_q)
            S_CORE_RD: begin
               core_rdata_o = mem_rdata_i;
               state_d      = S_IDLE;
            end
            S_DBG_RD: begin
               dbg_rvalid_o = 1'b1;
               dbg_rdata_o  = mem_rdata_i;
               state_d      = S_IDLE;
            end
            default: ;
         endcase

         // A store that wins in IDLE completes immediately; a load is released
         // in its data-return cycle. Everything else holds the core.
         core_stall_o = core_req_i && !(core_win && core_we_i) && (state_q != S_CORE_RD);

         // Counts every cycle debug waits, including read-return cycles.
         if (dbg_gnt_o || !dbg_req_i) begin
            starve_d = '0;
         end else if (starve_q != MAX_CNT) begin
            starve_d = starve_q + 1'b1;
         end
      end
   end

`ifdef MEM_ARB_PERF_EN
   logic [31:0] perf_stall_q, perf_stall_d;
   logic [31:0] perf_dbg_q, perf_dbg_d;

   always_comb begin
      perf_stall_d = perf_stall_q + {31'd0, core_stall_o};
      perf_dbg_d   = perf_dbg_q + {31'd0, dbg_gnt_o};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_q <= '0;
         perf_dbg_q   <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_dbg_q   <= perf_dbg_d;
      end
   end

   assign perf_stall_cnt_o = perf_stall_q;
   assign perf_dbg_cnt_o   = perf_dbg_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - table-driven self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        core_req_i = 1'b0, core_we_i = 1'b0;
   logic [7:0]  core_addr_i = '0;
   logic [31:0] core_wdata_i = '0;
   logic [31:0] core_rdata_o;
   logic        core_stall_o;
   logic        dbg_req_i = 1'b0, dbg_we_i = 1'b0;
   logic [7:0]  dbg_addr_i = '0;
   logic [31:0] dbg_wdata_i = '0;
   logic        dbg_gnt_o, dbg_rvalid_o;
   logic [31:0] dbg_rdata_o;
   logic [7:0]  mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_write_o, mem_read_o;
   logic [31:0] mem_rdata_i = '0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.MEM_WIDTH(8), .DATA_WIDTH(32), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
      .core_wdata_i(core_wdata_i), .core_rdata_o(core_rdata_o), .core_stall_o(core_stall_o),
      .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
      .dbg_wdata_i(dbg_wdata_i), .dbg_gnt_o(dbg_gnt_o), .dbg_rvalid_o(dbg_rvalid_o),
      .dbg_rdata_o(dbg_rdata_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_write_o(mem_write_o), .mem_read_o(mem_read_o), .mem_rdata_i(mem_rdata_i)
   );

   // Synchronous-read DataMemory model.
   logic [31:0] mem [256];
   always @(posedge clk) begin
      if (mem_write_o) mem[mem_addr_o] <= mem_wdata_o;
      if (mem_read_o)  mem_rdata_i <= mem[mem_addr_o];
   end

   typedef struct {
      logic        rst;
      logic        creq, cwe;
      logic [7:0]  caddr;
      logic [31:0] cwdata;
      logic        dreq, dwe;
      logic [7:0]  daddr;
      logic [31:0] dwdata;
      logic        ewr, erd;
      logic [7:0]  eaddr;
      logic [31:0] ewdata;
      logic        estall;
      logic [31:0] ecrd;
      logic        egnt, ervalid;
      logic [31:0] edrd;
   } vec_t;

   function automatic vec_t mk(
      logic r, logic cq, logic cw, logic [7:0] ca, logic [31:0] cd,
      logic dq, logic dw, logic [7:0] da, logic [31:0] dd,
      logic ewr, logic erd, logic [7:0] ea, logic [31:0] ed,
      logic es, logic [31:0] ecr, logic eg, logic ev, logic [31:0] edr);
      vec_t v;
      v.rst = r; v.creq = cq; v.cwe = cw; v.caddr = ca; v.cwdata = cd;
      v.dreq = dq; v.dwe = dw; v.daddr = da; v.dwdata = dd;
      v.ewr = ewr; v.erd = erd; v.eaddr = ea; v.ewdata = ed;
      v.estall = es; v.ecrd = ecr; v.egnt = eg; v.ervalid = ev; v.edrd = edr;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // Drive on the falling edge, sample mid-low-phase before the next rising edge.
   task automatic run_vec(vec_t v, string tag);
      @(negedge clk);
      rst = v.rst;
      core_req_i = v.creq; core_we_i = v.cwe; core_addr_i = v.caddr; core_wdata_i = v.cwdata;
      dbg_req_i = v.dreq; dbg_we_i = v.dwe; dbg_addr_i = v.daddr; dbg_wdata_i = v.dwdata;
      #4;
      check({tag, ".mem_write"},  {31'd0, mem_write_o},  {31'd0, v.ewr});
      check({tag, ".mem_read"},   {31'd0, mem_read_o},   {31'd0, v.erd});
      check({tag, ".core_stall"}, {31'd0, core_stall_o}, {31'd0, v.estall});
      check({tag, ".core_rdata"}, core_rdata_o,          v.ecrd);
      check({tag, ".dbg_gnt"},    {31'd0, dbg_gnt_o},    {31'd0, v.egnt});
      check({tag, ".dbg_rvalid"}, {31'd0, dbg_rvalid_o}, {31'd0, v.ervalid});
      check({tag, ".dbg_rdata"},  dbg_rdata_o,           v.edrd);
      if (v.ewr || v.erd) begin
         check({tag, ".mem_addr"},  {24'd0, mem_addr_o}, {24'd0, v.eaddr});
         check({tag, ".mem_wdata"}, mem_wdata_o,         v.ewdata);
      end
   endtask

   vec_t vecs[$];

   initial begin
      // rst, core{req,we,addr,wdata}, dbg{req,we,addr,wdata}, exp{wr,rd,addr,wdata}, stall, crdata, gnt, rvalid, drdata
      vecs.push_back(mk(1, 1,1,8'h10,32'hDEADBEEF, 1,1,8'h20,32'h12345678, 0,0,8'h00,32'h0, 0,32'h0, 0,0,32'h0));
      vecs.push_back(mk(0, 0,0,8'h00,32'h0,        0,0,8'h00,32'h0,        0,0,8'h00,32'h0, 0,32'h0, 0,0,32'h0));
      vecs.push_back(mk(0, 1,1,8'h10,32'hDEADBEEF, 0,0,8'h00,32'h0,        1,0,8'h10,32'hDEADBEEF, 0,32'h0, 0,0,32'h0));
      vecs.push_back(mk(0, 0,0,8'h00,32'h0,        1,1,8'h20,32'h12345678, 1,0,8'h20,32'h12345678, 0,32'h0, 1,0,32'h0));
      vecs.push_back(mk(0, 1,0,8'h10,32'h0,        0,0,8'h00,32'h0,        0,1,8'h10,32'h0, 1,32'h0, 0,0,32'h0));
      vecs.push_back(mk(0, 1,0,8'h10,32'h0,        0,0,8'h00,32'h0,        0,0,8'h00,32'h0, 0,32'hDEADBEEF, 0,0,32'h0));
      vecs.push_back(mk(0, 0,0,8'h00,32'h0,        1,0,8'h20,32'h0,        0,1,8'h20,32'h0, 0,32'h0, 1,0,32'h0));
      vecs.push_back(mk(0, 0,0,8'h00,32'h0,        0,0,8'h00,32'h0,        0,0,8'h00,32'h0, 0,32'h0, 0,1,32'h12345678));
      // back-to-back core loads with debug read held: debug forced in at starve==4
      vecs.push_back(mk(0, 1,0,8'h10,32'h0,        1,0,8'h20,32'h0,        0,1,8'h10,32'h0, 1,32'h0, 0,0,32'h0));
      vecs.push_back(mk(0, 1,0,8'h10,32'h0,        1,0,8'h20,32'h0,        0,0,8'h00,32'h0, 0,32'hDEADBEEF, 0,0,32'h0));
      vecs.push_back(mk(0, 1,0,8'h10,32'h0,        1,0,8'h20,32'h0,        0,1,8'h10,32'h0, 1,32'h0, 0,0,32'h0));
      vecs.push_back(mk(0, 1,0,8'h10,32'h0,        1,0,8'h20,32'h0,        0,0,8'h00,32'h0, 0,32'hDEADBEEF, 0,0,32'h0));
      vecs.push_back(mk(0, 1,0,8'h10,32'h0,        1,0,8'h20,32'h0,        0,1,8'h20,32'h0, 1,32'h0, 1,0,32'h0));
      vecs.push_back(mk(0, 1,0,8'h10,32'h0,        0,0,8'h00,32'h0,        0,0,8'h00,32'h0, 1,32'h0, 0,1,32'h12345678));
      vecs.push_back(mk(0, 1,0,8'h10,32'h0,        0,0,8'h00,32'h0,        0,1,8'h10,32'h0, 1,32'h0, 0,0,32'h0));
      vecs.push_back(mk(0, 1,0,8'h10,32'h0,        0,0,8'h00,32'h0,        0,0,8'h00,32'h0, 0,32'hDEADBEEF, 0,0,32'h0));
      // same-cycle core store + debug write
      vecs.push_back(mk(0, 1,1,8'h40,32'h11111111, 1,1,8'h44,32'h22222222, 1,0,8'h40,32'h11111111, 0,32'h0, 0,0,32'h0));
      vecs.push_back(mk(0, 0,0,8'h00,32'h0,        1,1,8'h44,32'h22222222, 1,0,8'h44,32'h22222222, 0,32'h0, 1,0,32'h0));
      vecs.push_back(mk(0, 0,0,8'h00,32'h0,        1,0,8'h44,32'h0,        0,1,8'h44,32'h0, 0,32'h0, 1,0,32'h0));
      vecs.push_back(mk(0, 0,0,8'h00,32'h0,        0,0,8'h00,32'h0,        0,0,8'h00,32'h0, 0,32'h0, 0,1,32'h22222222));
      // reset during DBG_RD discards the return
      vecs.push_back(mk(0, 0,0,8'h00,32'h0,        1,0,8'h20,32'h0,        0,1,8'h20,32'h0, 0,32'h0, 1,0,32'h0));
      vecs.push_back(mk(1, 0,0,8'h00,32'h0,        0,0,8'h00,32'h0,        0,0,8'h00,32'h0, 0,32'h0, 0,0,32'h0));
      vecs.push_back(mk(0, 1,0,8'h40,32'h0,        1,0,8'h20,32'h0,        0,1,8'h40,32'h0, 1,32'h0, 0,0,32'h0));
      vecs.push_back(mk(0, 1,0,8'h40,32'h0,        1,0,8'h20,32'h0,        0,0,8'h00,32'h0, 0,32'h11111111, 0,0,32'h0));
      vecs.push_back(mk(0, 0,0,8'h00,32'h0,        1,0,8'h20,32'h0,        0,1,8'h20,32'h0, 0,32'h0, 1,0,32'h0));
      vecs.push_back(mk(0, 0,0,8'h00,32'h0,        0,0,8'h00,32'h0,        0,0,8'h00,32'h0, 0,32'h0, 0,1,32'h12345678));
      // debug withdraws before grant: no debug access
      vecs.push_back(mk(0, 1,0,8'h10,32'h0,        1,1,8'h60,32'h99,       0,1,8'h10,32'h0, 1,32'h0, 0,0,32'h0));
      vecs.push_back(mk(0, 1,0,8'h10,32'h0,        0,0,8'h00,32'h0,        0,0,8'h00,32'h0, 0,32'hDEADBEEF, 0,0,32'h0));
      vecs.push_back(mk(0, 0,0,8'h00,32'h0,        0,0,8'h00,32'h0,        0,0,8'h00,32'h0, 0,32'h0, 0,0,32'h0));

      foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

      // Starve counter saturates at MAX_WAIT during a read-return cycle, and
      // debug still wins at the following IDLE cycle.
      run_vec(mk(0, 1,1,8'h50,32'h1, 1,0,8'h20,32'h0, 1,0,8'h50,32'h1, 0,32'h0, 0,0,32'h0), "sat_a");
      run_vec(mk(0, 1,1,8'h54,32'h2, 1,0,8'h20,32'h0, 1,0,8'h54,32'h2, 0,32'h0, 0,0,32'h0), "sat_b");
      run_vec(mk(0, 1,1,8'h58,32'h3, 1,0,8'h20,32'h0, 1,0,8'h58,32'h3, 0,32'h0, 0,0,32'h0), "sat_c");
      run_vec(mk(0, 1,0,8'h10,32'h0, 1,0,8'h20,32'h0, 0,1,8'h10,32'h0, 1,32'h0, 0,0,32'h0), "sat_d");
      run_vec(mk(0, 0,0,8'h00,32'h0, 1,0,8'h20,32'h0, 0,0,8'h00,32'h0, 0,32'hDEADBEEF, 0,0,32'h0), "sat_e");
      run_vec(mk(0, 1,0,8'h50,32'h0, 1,0,8'h20,32'h0, 0,1,8'h20,32'h0, 1,32'h0, 1,0,32'h0), "sat_f");
      run_vec(mk(0, 1,0,8'h50,32'h0, 0,0,8'h00,32'h0, 0,0,8'h00,32'h0, 1,32'h0, 0,1,32'h12345678), "sat_g");
      run_vec(mk(0, 1,0,8'h50,32'h0, 0,0,8'h00,32'h0, 0,1,8'h50,32'h0, 1,32'h0, 0,0,32'h0), "sat_h");
      run_vec(mk(0, 1,0,8'h50,32'h0, 0,0,8'h00,32'h0, 0,0,8'h00,32'h0, 0,32'h1, 0,0,32'h0), "sat_i");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
